// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - oversampled I2C target with auto-incrementing byte register bank
// Local register port shares the bank; an I2C commit wins a same-cycle, same-register local write.
module i2c_target_regfile #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       my_addr,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [PTR_W-1:0] loc_addr,
  input  logic             loc_we,
  input  logic [7:0]       loc_wdata,
  output logic [7:0]       loc_rdata,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_e;

  state_e           state_q;
  logic [2:0]       scl_q, sda_q;
  logic [2:0]       bit_cnt_q;
  logic             last_q;
  logic             rw_q;
  logic [7:0]       shift_q, tx_q;
  logic [PTR_W-1:0] ptr_q;
  logic             sda_oe_q, busy_q, wr_stb_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       loc_rdata_q;
  logic [7:0]       regs_q [DEPTH];

  // [0]/[1] form the synchroniser, [2] is the edge-detect history
  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign sda_rise  = sda_q[1] & ~sda_q[2];
  assign sda_fall  = ~sda_q[1] & sda_q[2];
  assign start_det = sda_fall & scl_q[1];
  assign stop_det  = sda_rise & scl_q[1];

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign loc_rdata = loc_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      last_q      <= 1'b0;
      rw_q        <= 1'b0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      loc_rdata_q <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
    end else begin
      scl_q       <= {scl_q[1:0], scl_i};
      sda_q       <= {sda_q[1:0], sda_i};
      wr_stb_q    <= 1'b0;
      loc_rdata_q <= regs_q[loc_addr];
      if (loc_we) regs_q[loc_addr] <= loc_wdata;

      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= 3'd7;
        last_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        // The falling edge of START itself arrives with last_q clear and is ignored
        if (scl_rise) begin
          shift_q   <= {shift_q[6:0], sda_q[1]};
          bit_cnt_q <= bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) last_q <= 1'b1;
        end
        if (scl_fall) begin
          case (state_q)
            ADDR: if (last_q) begin
              last_q <= 1'b0;
              if (shift_q[7:1] == my_addr) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                rw_q     <= shift_q[0];
                state_q  <= ADDR_ACK;
              end else begin
                state_q <= WAIT;
              end
            end
            ADDR_ACK: begin
              bit_cnt_q <= 3'd7;
              last_q    <= 1'b0;
              if (rw_q) begin
                tx_q     <= regs_q[ptr_q];
                sda_oe_q <= ~regs_q[ptr_q][7];
                state_q  <= RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= PTR;
              end
            end
            PTR: if (last_q) begin
              last_q   <= 1'b0;
              ptr_q    <= shift_q[PTR_W-1:0];
              sda_oe_q <= 1'b1;
              state_q  <= PTR_ACK;
            end
            PTR_ACK, WDATA_ACK: begin
              bit_cnt_q <= 3'd7;
              last_q    <= 1'b0;
              sda_oe_q  <= 1'b0;
              state_q   <= WDATA;
            end
            WDATA: if (last_q) begin
              last_q        <= 1'b0;
              regs_q[ptr_q] <= shift_q;
              wr_stb_q      <= 1'b1;
              wr_addr_q     <= ptr_q;
              ptr_q         <= ptr_q + 1'b1;
              sda_oe_q      <= 1'b1;
              state_q       <= WDATA_ACK;
            end
            RDATA: begin
              if (last_q) begin
                last_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                ptr_q    <= ptr_q + 1'b1;
                state_q  <= RDATA_ACK;
              end else begin
                sda_oe_q <= ~tx_q[bit_cnt_q];
              end
            end
            RDATA_ACK: begin
              bit_cnt_q <= 3'd7;
              last_q    <= 1'b0;
              if (!shift_q[0]) begin
                tx_q     <= regs_q[ptr_q];
                sda_oe_q <= ~regs_q[ptr_q][7];
                state_q  <= RDATA;
              end else begin
                state_q <= WAIT;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
